smpl_rate_gen: RTL

SMPL_RATE_GEN -- requirements
Module: smpl_rate_gen

---
 rtl/smpl_rate_gen_if.sv | 31 +++
 rtl/smpl_rate_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/smpl_rate_gen_if.sv
// smpl_rate_gen_if: control/status bundle between the capture controller
// (master) and the sample-rate generator (slave).
interface smpl_rate_gen_if;
    logic [1:0]  i_smpl_clk_sel;
    logic        i_run;
    logic        o_smpl_en;
    logic        o_smpl_clk;
    logic [1:0]  o_sel_active;
    logic        o_rate_chg;
    logic [15:0] o_smpl_cnt;

    modport master (
        output i_smpl_clk_sel,
        output i_run,
        input  o_smpl_en,
        input  o_smpl_clk,
        input  o_sel_active,
        input  o_rate_chg,
        input  o_smpl_cnt
    );

    modport slave (
        input  i_smpl_clk_sel,
        input  i_run,
        output o_smpl_en,
        output o_smpl_clk,
        output o_sel_active,
        output o_rate_chg,
        output o_smpl_cnt
    );
endinterface

// File: rtl/smpl_rate_gen.sv
// smpl_rate_gen: programmable sample-strobe divider with glitch-free rate switching.
// Optional square-wave sample clock output built only when SMPL_CLK_OUT_EN is defined;
// otherwise o_smpl_clk is tied low.
module smpl_rate_gen #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DIV0  = 2,
    parameter int unsigned DIV1  = 10,
    parameter int unsigned DIV2  = 100,
    parameter int unsigned DIV3  = 1000
) (
    input  logic           clk,
    input  logic           i_reset,
    smpl_rate_gen_if.slave bus
);

    // One extra bit so a divider of exactly 2^CNT_W is representable.
    localparam logic [CNT_W:0] Div0W = (CNT_W+1)'(DIV0);
    localparam logic [CNT_W:0] Div1W = (CNT_W+1)'(DIV1);
    localparam logic [CNT_W:0] Div2W = (CNT_W+1)'(DIV2);
    localparam logic [CNT_W:0] Div3W = (CNT_W+1)'(DIV3);
    localparam logic [CNT_W:0] OneW  = (CNT_W+1)'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [15:0]      scnt_q, scnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             chg_q, chg_d;
    logic [CNT_W:0]   div_act;
    logic             term;
    logic             sel_diff;

    // Divider applied for the currently active selection.
    always_comb begin
        div_act = Div0W;
        unique case (sel_q)
            2'b00:   div_act = Div0W;
            2'b01:   div_act = Div1W;
            2'b10:   div_act = Div2W;
            default: div_act = Div3W;
        endcase
    end

    assign term     = ({1'b0, cnt_q} == (div_act - OneW));
    // The pending request is the live selector input: whatever it holds at the
    // applying edge wins, so intermediate values are discarded for free.
    assign sel_diff = (bus.i_smpl_clk_sel != sel_q);

`ifdef SMPL_CLK_OUT_EN
    logic sclk_q, sclk_d;
`endif

    // Next-state: idle clears the divider, running counts and strobes on terminal count.
    always_comb begin
        cnt_d  = cnt_q;
        en_d   = 1'b0;
        scnt_d = scnt_q;
        sel_d  = sel_q;
        chg_d  = 1'b0;
`ifdef SMPL_CLK_OUT_EN
        sclk_d = sclk_q;
`endif
        if (!bus.i_run) begin
            cnt_d  = '0;
            scnt_d = '0;
`ifdef SMPL_CLK_OUT_EN
            sclk_d = 1'b0;
`endif
            if (sel_diff) begin
                sel_d = bus.i_smpl_clk_sel;
                chg_d = 1'b1;
            end
        end else if (term) begin
            cnt_d  = '0;
            en_d   = 1'b1;
            scnt_d = scnt_q + 16'd1;
`ifdef SMPL_CLK_OUT_EN
            sclk_d = ~sclk_q;
`endif
            // Rate switches only at a period boundary so no period is truncated.
            if (sel_diff) begin
                sel_d = bus.i_smpl_clk_sel;
                chg_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            scnt_q <= '0;
            sel_q  <= 2'b00;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            scnt_q <= scnt_d;
            sel_q  <= sel_d;
            chg_q  <= chg_d;
        end
    end

`ifdef SMPL_CLK_OUT_EN
    // Sample-clock toggle register, flips on every strobe.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk_d;
        end
    end

    assign bus.o_smpl_clk = sclk_q;
`else
    assign bus.o_smpl_clk = 1'b0;
`endif

    assign bus.o_smpl_en    = en_q;
    assign bus.o_smpl_cnt   = scnt_q;
    assign bus.o_sel_active = sel_q;
    assign bus.o_rate_chg   = chg_q;

endmodule
